// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer. It computes one bit per cycle on operand
// magnitudes, applies a sign fix-up, and then issues a single-cycle HI/LO write.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             wen_hilo,
    output logic [WIDTH-1:0] w_hi,
    output logic [WIDTH-1:0] w_lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t state;
    state_t state_next;

    logic                 is_div;
    logic                 neg_res;   // negate product / quotient
    logic                 neg_rem;   // remainder takes dividend sign
    logic                 dz;
    logic [WIDTH-1:0]     a_raw;
    logic [WIDTH-1:0]     opnd;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   prod;      // product accumulator; low half holds quotient when dividing
    logic [WIDTH:0]       rem;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;

    logic                 last_iter;
    logic                 signed_op;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_ok;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign signed_op = op[0];
    assign a_abs     = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_abs     = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;

    // Right-shifting shift-add: the carry of each partial sum re-enters at the top.
    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);

    // Restoring divide: the dividend bits stream out of the top of prod's low half.
    assign div_shift = {rem[WIDTH-1:0], prod[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ok    = (div_shift >= {1'b0, opnd});

    assign prod_fix  = neg_res ? -prod : prod;
    assign quo_fix   = neg_res ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    assign rem_fix   = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            a_raw   <= '0;
            opnd    <= '0;
            prod    <= '0;
            rem     <= '0;
            cnt     <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div  <= op[1];
                        a_raw   <= src_a;
                        dz      <= op[1] && (src_b == '0);
                        neg_res <= signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_rem <= signed_op && src_a[WIDTH-1];
                        opnd    <= op[1] ? b_abs : a_abs;
                        prod    <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
                        rem     <= '0;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        rem  <= div_ok ? div_diff : div_shift;
                        prod <= {prod[2*WIDTH-1:WIDTH], prod[WIDTH-2:0], div_ok};
                    end else begin
                        prod <= {mul_sum, prod[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (!is_div) begin
                        hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix[WIDTH-1:0];
                    end else if (dz) begin
                        // Divide by zero reports the raw dividend and an all-ones quotient.
                        hi_r <= a_raw;
                        lo_r <= '1;
                    end else begin
                        hi_r <= rem_fix;
                        lo_r <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign stall    = ((state == IDLE) && start) || (state == RUN) || (state == FIX);
    assign done     = (state == DONE);
    assign wen_hilo = (state == DONE);
    assign div_zero = (state == DONE) && dz;
    assign w_hi     = hi_r;
    assign w_lo     = lo_r;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU that owns the write side of the HI/LO register pair.
- It captures operands from the register-file read ports, runs an iterative shift-add multiply or restoring divide (one bit per cycle), and applies a sign fix-up.
- It then issues a single-cycle HI/LO write and holds the PC stalled while it works.
- It sits beside the ALU and drives the HI/LO block's wen/w_hi/w_lo inputs.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request an operation; sampled only in IDLE
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- src_a  input  WIDTH  multiplicand / dividend (rs)
- src_b  input  WIDTH  multiplier / divisor (rt)
- stall  output  1  PC/IR hold request to the core
- busy  output  1  operation in flight
- done  output  1  one-cycle completion pulse
- div_zero  output  1  valid with done; divisor was zero
- wen_hilo  output  1  HI/LO write enable, asserted together with done
- w_hi  output  WIDTH  HI write data (product high word / remainder)
- w_lo  output  WIDTH  LO write data (product low word / quotient)

Behaviour:
- Reset (synchronous, active-high, wins over everything)
  - State becomes IDLE; counter and all datapath registers clear to 0.
  - busy=0, done=0, div_zero=0, wen_hilo=0, w_hi=0, w_lo=0, stall=0.
- States: IDLE, RUN, FIX, DONE.
- IDLE
  - On an edge with start=1: latch op.
  - Latch the absolute values of src_a and src_b (absolute value only for signed ops); latch the result signs; go to RUN with cnt=0.
  - start=0: stay in IDLE.
- RUN: one iteration per edge; cnt increments; after the iteration with cnt==WIDTH-1 go to FIX.
  - Multiply: 2*WIDTH-bit accumulator, shift-add on the multiplier LSB.
  - Divide: restoring shift-subtract. The remainder register is WIDTH+1 bits, so no overflow loss.
- FIX: one edge. Register the final results, then go to DONE.
  - Negate the product if the operand signs differ (signed MULT).
  - Negate the quotient if the operand signs differ; the remainder takes the dividend's sign (signed DIV).
- DONE: combinational done=1 and wen_hilo=1 for exactly one cycle; w_hi/w_lo are stable; go to IDLE on the next edge.
  - start is ignored in DONE; a new operation needs IDLE.
- Latency
  - Accepting edge E0; RUN iterations on E1..E32 (WIDTH=32); FIX registers results on E33; done/wen_hilo are high in the cycle after E33.
  - A new start is accepted earliest at E35, giving one issue per 35 cycles.
  - Latency is identical for all ops, including divide-by-zero.
- busy=1 in RUN, FIX and DONE.
- stall = (IDLE & start) | RUN | FIX. stall is 0 in DONE, so the PC advances on the same edge that HI/LO is written.
- Operands are captured only at acceptance; src_a/src_b changes mid-operation have no effect.
- Divide by zero (DIV or DIVU): HI=src_a as captured (unsigned bit pattern), LO=all ones, div_zero=1 with done. It is not an exception.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, div_zero=0. This is natural two's-complement wrap.
- Between operations, w_hi/w_lo hold their last values; only wen_hilo qualifies them.
- Reset mid-operation (RUN or FIX): abort with no HI/LO write; IDLE and all outputs 0 on the next cycle.
- Reset coincident with start: reset wins; the request is not accepted.
- An illegal or unreachable state returns to IDLE.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> one-cycle wen_hilo in the cycle after the 33rd edge following acceptance; HI=0xFFFFFFFE, LO=0x00000001; stall high for 34 cycles starting with the start cycle.
- MULT 0xFFFFFFFD (-3) x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> LO=0x7FFFFFFC, HI=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100 / 0 -> HI=0x00000064, LO=0xFFFFFFFF, div_zero=1 with done, same latency. The next operation, DIVU 100 / 7, gives div_zero=0, LO=14, HI=2.
- Change src_a/src_b and pulse start during RUN and DONE -> results reflect the originally captured operands; no second operation starts until IDLE.
- Assert rst for one cycle at RUN iteration 10 -> wen_hilo never asserts for that operation; busy=0 and stall=0 next cycle. A following MULTU 3 x 5 yields HI=0, LO=15.
